mem_io_responder: RTL and testbench
===================================

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter: RAM_AW, default 17, RAM byte-address width (128 KB).
REQ-002 Parameter: TXQ_DEPTH, default 8, TX byte queue depth (power of 2, >=4).
REQ-003 The block SHALL have exactly these ports:
- clk_in  in  1  sole clock, rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- mem_a  in  32  CPU byte address; only [17:0] decoded.
- mem_wr  in  1  1 = write, 0 = read.
- mem_dout  in  8  CPU write data.
- mem_din  out  8  read data to CPU.
- rx_valid  in  1  input byte available.
- rx_data  in  8  input byte.
- rx_pop  out  1  consume input byte.
- tx_valid  out  1  output byte available.
- tx_data  out  8  output byte.
- tx_ready  in  1  sink accepts tx_data.
- rdy_out  out  1  CPU ready (drives CPU rdy_in).
- halt  out  1  program stopped.

Function
REQ-004 The block SHALL decode IO when mem_a[17:16]==2'b11 and RAM otherwise, using RAM address mem_a[RAM_AW-1:0].
REQ-005 The block SHALL treat every cycle as a request (no strobe): mem_wr=0 is a read, mem_wr=1 a write.
REQ-006 RAM write SHALL complete in the edge of the same cycle.
REQ-007 Read data SHALL be registered: mem_din is valid in the cycle after the address (1-cycle latency, 2-cycle CPU read).
REQ-008 A read of an address written in the previous cycle SHALL return the new byte.
REQ-009 A read of 0x30000 SHALL return rx_data if rx_valid=1, else 0x00.
REQ-010 rx_pop SHALL pulse for exactly that cycle when rx_valid=1 and the address is 0x30000; the CPU presents such a read for exactly one cycle.
REQ-011 Reads of 0x30004..0x30007 SHALL return bytes 0..3 (little-endian) of the cycle snapshot.
REQ-012 The snapshot SHALL be latched from the 32-bit free-running cycle counter on a read of 0x30004.
REQ-013 The cycle counter SHALL increment every cycle after reset and wrap from 0xFFFFFFFF to 0.
REQ-014 Reads of other IO addresses SHALL return 0x00.
REQ-015 A write of a nonzero byte to 0x30000 SHALL push that byte to the TX queue; a write of 0x00 SHALL be ignored.
REQ-016 The TX queue SHALL be FIFO and present its head on tx_data with tx_valid = !empty.
REQ-017 The TX queue SHALL pop on tx_valid & tx_ready.
REQ-018 Simultaneous push and pop SHALL keep occupancy unchanged, including when full.
REQ-019 A push to a full queue SHALL be dropped, with no change to queue state.
REQ-020 rdy_out SHALL be registered and equal 0 while occupancy >= TXQ_DEPTH-1, leaving a slot for one in-flight write.
REQ-021 A write to 0x30004 SHALL set a sticky stop flag.
REQ-022 halt SHALL assert (sticky) in the first cycle where the stop flag is set and the TX queue is empty.
REQ-023 rdy_out SHALL be 0 from the cycle after the stop flag is set.
REQ-024 Writes to other IO addresses SHALL be ignored.

Reset
REQ-025 While rst_in=0, outputs SHALL be: mem_din=0x00, rx_pop=0, tx_valid=0, tx_data=0x00, rdy_out=0, halt=0.
REQ-026 While rst_in=0, the counter, snapshot, queue pointers and stop flag SHALL be 0.
REQ-027 RAM contents SHALL NOT be reset.
REQ-028 Assertion mid-transfer SHALL discard queued TX bytes.
REQ-029 rdy_out SHALL rise on the first clock edge after rst_in deasserts.

Configuration
REQ-030 Macro IO_CYCLE_COUNTER_EN: when defined, REQ-011..013 apply.
REQ-031 When IO_CYCLE_COUNTER_EN is undefined, the counter and snapshot SHALL be absent and reads of 0x30004..0x30007 SHALL return 0x00.

Verification
REQ-032 Write 0xA5 to 0x00010, then read 0x00010 next cycle -> mem_din=0xA5 one cycle after the read address.
REQ-033 rx_valid=1, rx_data=0x41, read 0x30000 -> mem_din=0x41 next cycle, rx_pop high one cycle. With rx_valid=0 -> mem_din=0x00, no pop.
REQ-034 tx_ready=0; write 0x31..0x38 to 0x30000 -> rdy_out=0 once occupancy reaches 7. Eighth byte accepted, ninth dropped. Write of 0x00 leaves occupancy unchanged.
REQ-035 Full queue; same-cycle push 0x39 and pop (tx_ready=1) -> occupancy stays 8, head advances, 0x39 at tail.
REQ-036 Read 0x30004 at counter=0x00000123, then read 0x30004..0x30007 -> bytes 0x23, 0x01, 0x00, 0x00. With macro undefined -> all 0x00.
REQ-037 Queue holds 2 bytes, write 0x30004, then tx_ready=1 -> rdy_out=0 next cycle, halt=1 once the queue is empty. Pulse rst_in=0 -> halt=0, tx_valid=0.

Source files
------------

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte-wide memory and IO responder for a simple CPU bus.
//
// Every cycle is a request: mem_wr=1 writes, mem_wr=0 reads. mem_a[17:16]==2'b11 selects IO,
// anything else selects RAM at mem_a[RAM_AW-1:0]. Read data is registered (one-cycle latency).
//
// IO map (mem_a[17:0]):
//   0x30000 read  : rx_data when rx_valid (pops it), else 0x00
//   0x30000 write : nonzero byte pushed to the TX queue, 0x00 ignored
//   0x30004 read  : byte 0 of the cycle counter, latching the full counter into the snapshot
//   0x30005-7 read: bytes 1..3 of the snapshot
//   0x30004 write : sets the sticky stop flag
//   other IO      : reads return 0x00, writes ignored
//
// Ports:
//   clk_in, rst_in      clock (rising edge), asynchronous active-low reset
//   mem_a/mem_wr        CPU address and direction
//   mem_dout/mem_din    CPU write data / registered read data
//   rx_valid/rx_data    input byte source, rx_pop consumes it
//   tx_valid/tx_data    TX queue head, popped when tx_ready
//   rdy_out             CPU ready, low when the queue is nearly full or after stop
//   halt                sticky, set once stopped and the TX queue has drained
//
// Optional feature: define IO_CYCLE_COUNTER_EN to build the cycle counter and snapshot;
// without it, reads of 0x30004..0x30007 return 0x00.

module mem_io_responder #(
    parameter int unsigned RAM_AW    = 17,
    parameter int unsigned TXQ_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        rdy_out,
    output logic        halt
);

    localparam int unsigned PtrW = $clog2(TXQ_DEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW+1)'(TXQ_DEPTH);
    // One slot stays free for the write the CPU may issue while it sees rdy fall.
    localparam logic [PtrW:0] RdyLimit  = (PtrW+1)'(TXQ_DEPTH - 1);

    // Upper address bits are not decoded.
    logic unused_addr;
    assign unused_addr = ^mem_a[31:18];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic        io_sel;
    logic        io_rd;
    logic        io_wr;
    logic        sel_data;
    logic        sel_ctrl;
    logic [RAM_AW-1:0] ram_addr;

    assign io_sel   = (mem_a[17:16] == 2'b11);
    assign io_rd    = io_sel & ~mem_wr;
    assign io_wr    = io_sel & mem_wr;
    assign sel_data = (mem_a[17:0] == 18'h30000);
    assign sel_ctrl = (mem_a[17:0] == 18'h30004);
    assign ram_addr = mem_a[RAM_AW-1:0];

    // ------------------------------------------------------------------
    // RAM (contents are not reset)
    // ------------------------------------------------------------------
    logic [7:0] ram_mem [2**RAM_AW];

    always_ff @(posedge clk_in) begin
        if (mem_wr && !io_sel) begin
            ram_mem[ram_addr] <= mem_dout;
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter and snapshot
    // ------------------------------------------------------------------
`ifdef IO_CYCLE_COUNTER_EN
    logic [31:0] cyc_q;
    logic [31:0] snap_q;
    logic [31:0] snap_d;

    always_comb begin
        snap_d = snap_q;
        if (io_rd && sel_ctrl) begin
            snap_d = cyc_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cyc_q  <= 32'h0;
            snap_q <= 32'h0;
        end else begin
            cyc_q  <= cyc_q + 32'd1;
            snap_q <= snap_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
    logic [7:0] rdata_d;
    logic [7:0] mem_din_q;

    always_comb begin
        rdata_d = 8'h00;
        if (!io_sel) begin
            rdata_d = ram_mem[ram_addr];
        end else if (!mem_wr) begin
            case (mem_a[15:0])
                16'h0000: rdata_d = rx_valid ? rx_data : 8'h00;
`ifdef IO_CYCLE_COUNTER_EN
                // The byte-0 read returns the value being latched, so a 0x30004..0x30007
                // sequence reads one coherent 32-bit count.
                16'h0004: rdata_d = cyc_q[7:0];
                16'h0005: rdata_d = snap_q[15:8];
                16'h0006: rdata_d = snap_q[23:16];
                16'h0007: rdata_d = snap_q[31:24];
`endif
                default:  rdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mem_din_q <= 8'h00;
        end else begin
            mem_din_q <= rdata_d;
        end
    end

    assign mem_din = mem_din_q;
    assign rx_pop  = rst_in & io_rd & sel_data & rx_valid;

    // ------------------------------------------------------------------
    // TX queue
    // ------------------------------------------------------------------
    logic [7:0]    txq_mem [TXQ_DEPTH];
    logic [PtrW:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0] count_q, count_d;
    logic          txq_empty;
    logic          txq_full;
    logic          push_req;
    logic          push;
    logic          pop;

    assign count_q   = wr_ptr_q - rd_ptr_q;
    assign txq_empty = (count_q == '0);
    assign txq_full  = (count_q == FullCount);
    assign push_req  = io_wr & sel_data & (mem_dout != 8'h00);
    assign pop       = ~txq_empty & tx_ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push      = push_req & (~txq_full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    assign count_d = wr_ptr_d - rd_ptr_d;

    always_ff @(posedge clk_in) begin
        if (push) begin
            txq_mem[wr_ptr_q[PtrW-1:0]] <= mem_dout;
        end
    end

    assign tx_valid = ~txq_empty;
    assign tx_data  = txq_empty ? 8'h00 : txq_mem[rd_ptr_q[PtrW-1:0]];

    // ------------------------------------------------------------------
    // Stop / halt / ready
    // ------------------------------------------------------------------
    logic stop_q, stop_d;
    logic halt_q;
    logic rdy_q, rdy_d;

    assign stop_d = stop_q | (io_wr & sel_ctrl);
    // Computed from next-state so rdy_out tracks occupancy and stop without an extra lag.
    assign rdy_d  = (count_d < RdyLimit) & ~stop_d;
    assign halt   = halt_q | (stop_q & txq_empty);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            stop_q   <= 1'b0;
            halt_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            stop_q   <= stop_d;
            halt_q   <= halt;
            rdy_q    <= rdy_d;
        end
    end

    assign rdy_out = rdy_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Testbench for mem_io_responder: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a queue/array reference model.

module tb_mem_io_responder;

    localparam int TXQ_DEPTH = 8;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_pop;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rdy_out;
    logic        halt;

    mem_io_responder #(
        .RAM_AW    (17),
        .TXQ_DEPTH (TXQ_DEPTH)
    ) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr),
        .mem_dout (mem_dout),
        .mem_din  (mem_din),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_pop   (rx_pop),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rdy_out  (rdy_out),
        .halt     (halt)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0]  q_m [$];
    logic [7:0]  ram_m [int];
    logic [31:0] cnt_m;
    logic        stop_m;
    logic        halt_m;
    logic        rdy_m;
`ifdef IO_CYCLE_COUNTER_EN
    logic [31:0] snap_m;
    localparam logic [31:0] SnapExp = 32'h0000_0123;
`else
    localparam logic [31:0] SnapExp = 32'h0000_0000;
`endif

    // Observed values returned by do_cycle
    logic       ob_pop, ob_txv, ob_rdy, ob_halt;
    logic [7:0] ob_txd, ob_din;

    typedef struct {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  d;
        logic        rxv;
        logic [7:0]  rxd;
        logic        e_pop;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic        e_rdy;
        logic        chk_din;
        logic [7:0]  e_din;
    } vec_t;

    localparam int NVec = 17;
    vec_t vecs [NVec];

    function automatic vec_t mk(logic [31:0] a, logic wr, logic [7:0] d, logic rxv,
                                logic [7:0] rxd, logic pop, logic txv, logic [7:0] txd,
                                logic rdy, logic chk, logic [7:0] din);
        vec_t v;
        v.a = a; v.wr = wr; v.d = d; v.rxv = rxv; v.rxd = rxd;
        v.e_pop = pop; v.e_txv = txv; v.e_txd = txd; v.e_rdy = rdy;
        v.chk_din = chk; v.e_din = din;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1. Drives one request cycle, checks same-cycle outputs against the model,
    // advances the model across the edge, then checks registered read data.
    task automatic do_cycle(input logic [31:0] a, input logic wr, input logic [7:0] d,
                            input logic rxv, input logic [7:0] rxd, input logic txr,
                            output logic o_pop, output logic o_txv, output logic [7:0] o_txd,
                            output logic o_rdy, output logic o_halt, output logic [7:0] o_din);
        logic [17:0] a18;
        logic        io;
        logic        e_halt;
        logic        din_known;
        logic [7:0]  e_din;
        a18 = a[17:0];
        io  = (a18[17:16] == 2'b11);
        mem_a = a; mem_wr = wr; mem_dout = d; rx_valid = rxv; rx_data = rxd; tx_ready = txr;
        #2;
        o_pop = rx_pop; o_txv = tx_valid; o_txd = tx_data; o_rdy = rdy_out; o_halt = halt;
        e_halt = halt_m || (stop_m && q_m.size() == 0);
        check("rx_pop", rx_pop, !wr && a18 == 18'h30000 && rxv);
        check("tx_valid", tx_valid, q_m.size() != 0);
        check("tx_data", tx_data, (q_m.size() != 0) ? q_m[0] : 8'h00);
        check("rdy_out", rdy_out, rdy_m);
        check("halt", halt, e_halt);

        din_known = 1'b0;
        e_din     = 8'h00;
        if (!wr) begin
            if (!io) begin
                if (ram_m.exists(int'(a[16:0]))) begin
                    din_known = 1'b1;
                    e_din     = ram_m[int'(a[16:0])];
                end
            end else begin
                din_known = 1'b1;
                case (a18)
                    18'h30000: e_din = rxv ? rxd : 8'h00;
`ifdef IO_CYCLE_COUNTER_EN
                    18'h30004: e_din = cnt_m[7:0];
                    18'h30005: e_din = snap_m[15:8];
                    18'h30006: e_din = snap_m[23:16];
                    18'h30007: e_din = snap_m[31:24];
`endif
                    default:   e_din = 8'h00;
                endcase
            end
        end

        if (txr && q_m.size() != 0) void'(q_m.pop_front());
        if (wr && a18 == 18'h30000 && d != 8'h00 && q_m.size() < TXQ_DEPTH) q_m.push_back(d);
`ifdef IO_CYCLE_COUNTER_EN
        if (!wr && a18 == 18'h30004) snap_m = cnt_m;
`endif
        if (wr && a18 == 18'h30004) stop_m = 1'b1;
        if (wr && !io) ram_m[int'(a[16:0])] = d;
        halt_m = e_halt;
        cnt_m  = cnt_m + 32'd1;
        rdy_m  = (q_m.size() < TXQ_DEPTH - 1) && !stop_m;

        @(posedge clk_in);
        #1;
        o_din = mem_din;
        if (din_known) check("mem_din", mem_din, e_din);
    endtask

    // Called at posedge+1. Asserts reset asynchronously, checks outputs, releases at posedge+1.
    task automatic do_reset();
        rst_in = 1'b0;
        mem_a = 32'h30000; mem_wr = 1'b0; mem_dout = 8'h00;
        rx_valid = 1'b1; rx_data = 8'h77; tx_ready = 1'b0;
        #2;
        check("rst mem_din", mem_din, 8'h00);
        check("rst rx_pop", rx_pop, 1'b0);
        check("rst tx_valid", tx_valid, 1'b0);
        check("rst tx_data", tx_data, 8'h00);
        check("rst rdy_out", rdy_out, 1'b0);
        check("rst halt", halt, 1'b0);
        repeat (3) @(posedge clk_in);
        #1;
        check("rst hold rdy_out", rdy_out, 1'b0);
        check("rst hold tx_valid", tx_valid, 1'b0);
        check("rst hold mem_din", mem_din, 8'h00);
        q_m.delete();
        cnt_m  = 32'h0;
        stop_m = 1'b0;
        halt_m = 1'b0;
        rdy_m  = 1'b0;
`ifdef IO_CYCLE_COUNTER_EN
        snap_m = 32'h0;
`endif
        rst_in = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        logic        wr;
        logic [7:0]  d;
        logic        txr;
        logic [31:0] snap_exp;
        int          guard;

        rst_in = 1'b1;
        mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00;
        rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        @(posedge clk_in);
        #1;
        do_reset();

        // ---------------- Directed vector table (tx_ready held low) ----------------
        //              a             wr    d      rxv   rxd    pop   txv   txd    rdy   chk   din
        vecs[0]  = mk(32'h00010,     1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        vecs[1]  = mk(32'h00010,     1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5);
        vecs[2]  = mk(32'h30000,     1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41);
        vecs[3]  = mk(32'h30000,     1'b0, 8'h00, 1'b0, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00);
        vecs[4]  = mk(32'hFFFF0008,  1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00);
        vecs[5]  = mk(32'h30000,     1'b1, 8'h31, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        vecs[6]  = mk(32'h30000,     1'b1, 8'h32, 1'b0, 8'h00, 1'b0, 1'b1, 8'h31, 1'b1, 1'b0, 8'h00);
        vecs[7]  = mk(32'h30000,     1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b1, 8'h31, 1'b1, 1'b0, 8'h00);
        vecs[8]  = mk(32'h30000,     1'b1, 8'h34, 1'b0, 8'h00, 1'b0, 1'b1, 8'h31, 1'b1, 1'b0, 8'h00);
        vecs[9]  = mk(32'h30000,     1'b1, 8'h35, 1'b0, 8'h00, 1'b0, 1'b1, 8'h31, 1'b1, 1'b0, 8'h00);
        vecs[10] = mk(32'h30000,     1'b1, 8'h36, 1'b0, 8'h00, 1'b0, 1'b1, 8'h31, 1'b1, 1'b0, 8'h00);
        vecs[11] = mk(32'h30000,     1'b1, 8'h37, 1'b0, 8'h00, 1'b0, 1'b1, 8'h31, 1'b1, 1'b0, 8'h00);
        vecs[12] = mk(32'h30000,     1'b1, 8'h38, 1'b0, 8'h00, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0, 8'h00);
        vecs[13] = mk(32'h30000,     1'b1, 8'h3A, 1'b0, 8'h00, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0, 8'h00);
        vecs[14] = mk(32'h30000,     1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0, 8'h00);
        vecs[15] = mk(32'h30008,     1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0, 8'h00);
        vecs[16] = mk(32'h00010,     1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h31, 1'b0, 1'b1, 8'hA5);

        for (int i = 0; i < NVec; i++) begin
            do_cycle(vecs[i].a, vecs[i].wr, vecs[i].d, vecs[i].rxv, vecs[i].rxd, 1'b0,
                     ob_pop, ob_txv, ob_txd, ob_rdy, ob_halt, ob_din);
            check($sformatf("vec%0d rx_pop", i), ob_pop, vecs[i].e_pop);
            check($sformatf("vec%0d tx_valid", i), ob_txv, vecs[i].e_txv);
            check($sformatf("vec%0d tx_data", i), ob_txd, vecs[i].e_txd);
            check($sformatf("vec%0d rdy_out", i), ob_rdy, vecs[i].e_rdy);
            if (vecs[i].chk_din) check($sformatf("vec%0d mem_din", i), ob_din, vecs[i].e_din);
        end

        // ---------------- Full queue: simultaneous push and pop ----------------
        do_cycle(32'h30000, 1'b1, 8'h39, 1'b0, 8'h00, 1'b1,
                 ob_pop, ob_txv, ob_txd, ob_rdy, ob_halt, ob_din);
        check("fullpp head", ob_txd, 8'h31);
        do_cycle(32'h30008, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0,
                 ob_pop, ob_txv, ob_txd, ob_rdy, ob_halt, ob_din);
        check("fullpp new head", ob_txd, 8'h32);
        check("fullpp rdy", ob_rdy, 1'b0);
        for (int i = 0; i < 8; i++) begin
            do_cycle(32'h30008, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1,
                     ob_pop, ob_txv, ob_txd, ob_rdy, ob_halt, ob_din);
            check($sformatf("drain%0d", i), ob_txd, 8'h32 + 8'(i));
        end
        do_cycle(32'h30008, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1,
                 ob_pop, ob_txv, ob_txd, ob_rdy, ob_halt, ob_din);
        check("drain empty", ob_txv, 1'b0);
        check("drain rdy", ob_rdy, 1'b1);

        // ---------------- Cycle counter snapshot ----------------
        guard = 0;
        while (cnt_m < 32'h123 && guard < 1000) begin
            do_cycle(32'h00010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0,
                     ob_pop, ob_txv, ob_txd, ob_rdy, ob_halt, ob_din);
            guard++;
        end
        snap_exp = SnapExp;
        do_cycle(32'h30004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0,
                 ob_pop, ob_txv, ob_txd, ob_rdy, ob_halt, ob_din);
        check("snap byte0", ob_din, snap_exp[7:0]);
        do_cycle(32'h30005, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0,
                 ob_pop, ob_txv, ob_txd, ob_rdy, ob_halt, ob_din);
        check("snap byte1", ob_din, snap_exp[15:8]);
        do_cycle(32'h30006, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0,
                 ob_pop, ob_txv, ob_txd, ob_rdy, ob_halt, ob_din);
        check("snap byte2", ob_din, snap_exp[23:16]);
        do_cycle(32'h30007, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0,
                 ob_pop, ob_txv, ob_txd, ob_rdy, ob_halt, ob_din);
        check("snap byte3", ob_din, snap_exp[31:24]);

        // ---------------- Randomized traffic ----------------
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 32'h00100 + $urandom_range(0, 15);
                4:          a = 32'h1FFF0 + $urandom_range(0, 15);
                5, 6:       a = 32'h30000;
                7:          a = 32'h30004 + $urandom_range(0, 3);
                8:          a = 32'h30008 + $urandom_range(0, 7);
                default:    a = 32'h20100 + $urandom_range(0, 15);
            endcase
            a  = a | ($urandom_range(0, 16383) << 18);
            wr = ($urandom_range(0, 1) == 0);
            if (a[17:0] == 18'h30004) wr = 1'b0;
            d   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            txr = (i < 750) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 0);
            do_cycle(a, wr, d, 1'($urandom), 8'($urandom), txr,
                     ob_pop, ob_txv, ob_txd, ob_rdy, ob_halt, ob_din);
        end

        // ---------------- Reset mid-transfer discards the queue ----------------
        for (int i = 0; i < 3; i++) begin
            do_cycle(32'h30000, 1'b1, 8'h51 + 8'(i), 1'b0, 8'h00, 1'b0,
                     ob_pop, ob_txv, ob_txd, ob_rdy, ob_halt, ob_din);
        end
        do_reset();
        do_cycle(32'h00010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1,
                 ob_pop, ob_txv, ob_txd, ob_rdy, ob_halt, ob_din);
        check("post-reset tx_valid", ob_txv, 1'b0);
        check("post-reset rdy low", ob_rdy, 1'b0);
        check("ram kept over reset", ob_din, 8'hA5);

        // ---------------- Stop flag and halt ----------------
        do_cycle(32'h30000, 1'b1, 8'h61, 1'b0, 8'h00, 1'b0,
                 ob_pop, ob_txv, ob_txd, ob_rdy, ob_halt, ob_din);
        check("rdy after reset", ob_rdy, 1'b1);
        do_cycle(32'h30000, 1'b1, 8'h62, 1'b0, 8'h00, 1'b0,
                 ob_pop, ob_txv, ob_txd, ob_rdy, ob_halt, ob_din);
        do_cycle(32'h30004, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0,
                 ob_pop, ob_txv, ob_txd, ob_rdy, ob_halt, ob_din);
        check("stop cycle rdy", ob_rdy, 1'b1);
        check("stop cycle halt", ob_halt, 1'b0);
        do_cycle(32'h00010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1,
                 ob_pop, ob_txv, ob_txd, ob_rdy, ob_halt, ob_din);
        check("stopped rdy", ob_rdy, 1'b0);
        check("stopped halt q2", ob_halt, 1'b0);
        check("stopped head", ob_txd, 8'h61);
        do_cycle(32'h00010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1,
                 ob_pop, ob_txv, ob_txd, ob_rdy, ob_halt, ob_din);
        check("stopped halt q1", ob_halt, 1'b0);
        check("stopped head2", ob_txd, 8'h62);
        do_cycle(32'h00010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1,
                 ob_pop, ob_txv, ob_txd, ob_rdy, ob_halt, ob_din);
        check("halt on empty", ob_halt, 1'b1);
        check("halt txv", ob_txv, 1'b0);
        do_cycle(32'h30000, 1'b1, 8'h63, 1'b0, 8'h00, 1'b0,
                 ob_pop, ob_txv, ob_txd, ob_rdy, ob_halt, ob_din);
        do_cycle(32'h00010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0,
                 ob_pop, ob_txv, ob_txd, ob_rdy, ob_halt, ob_din);
        check("halt sticky", ob_halt, 1'b1);
        do_reset();
        check("halt cleared", halt, 1'b0);
        check("tx cleared", tx_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
